// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserializer: MSB-first bits in over valid/ready, N-bit words out on a registered valid/ready port.
// Optional even-parity trailer bit per word enabled by defining SERIAL_TO_PARALLEL_PARITY_EN.
module serial_to_parallel #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_word,
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  output logic         out_parity_err,
`endif
  input  logic         out_ready
);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  localparam int L  = N + 1;
  localparam int SW = N;
`else
  // The final data bit goes straight into out_word, so only N-1 bits ever need holding.
  localparam int L  = N;
  localparam int SW = N - 1;
`endif
  localparam int CW = $clog2(L);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  logic [SW-1:0] shift;
  logic [CW-1:0] count;
  logic          last;
  logic          accept;
  logic          consume;

  assign last     = (count == LAST);
  assign in_ready = !reset && !(last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift     <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
      out_parity_err <= 1'b0;
`endif
    end else begin
      if (consume) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (!last) begin
          shift <= SW'({shift, in_bit});
          count <= count + 1'b1;
        end else begin
          count     <= '0;
          out_valid <= 1'b1;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
          out_word       <= shift;
          out_parity_err <= (^shift) ^ in_bit;
`else
          out_word       <= {shift, in_bit};
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed self-checking bench for serial_to_parallel with N=8; parity cases run when SERIAL_TO_PARALLEL_PARITY_EN is defined.
module tb_serial_to_parallel;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_word;
  logic       out_ready;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  logic       out_parity_err;
`endif

  int checks = 0;
  int errors = 0;

  serial_to_parallel #(.N(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_bit(in_bit),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_word(out_word),
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    .out_parity_err(out_parity_err),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      in_valid = 1'b1;
      in_bit   = w[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready_low got %b want 0", in_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_word !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release got v=%b w=%h r=%b want v=0 w=00 r=1", out_valid, out_word, in_ready);
    end
    for (int c = 0; c < 20; c++) begin
      in_bit = c[0];
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_word !== 8'h00 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL idle_cycle_%0d got v=%b w=%h r=%b want v=0 w=00 r=1", c, out_valid, out_word, in_ready);
      end
    end
  endtask

  task automatic test_single_word();
    out_ready = 1'b0;
    send_word(8'hA5);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 8'hA5) begin
      errors++; $display("[TB] FAIL single_word got v=%b w=%h want v=1 w=a5", out_valid, out_word);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_word !== 8'hA5) begin
        errors++; $display("[TB] FAIL single_hold_%0d got v=%b w=%h want v=1 w=a5", c, out_valid, out_word);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_word !== 8'hA5) begin
      errors++; $display("[TB] FAIL single_consume got v=%b w=%h want v=0 w=a5", out_valid, out_word);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w2;
    w2 = 8'hC3;
    out_ready = 1'b0;
    send_word(8'h3C);
    for (int i = 7; i >= 1; i--) begin
      in_valid = 1'b1; in_bit = w2[i];
      tick();
    end
    in_valid = 1'b1; in_bit = w2[0];
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 8'h3C) begin
        errors++;
        $display("[TB] FAIL stall_%0d got r=%b v=%b w=%h want r=0 v=1 w=3c", c, in_ready, out_valid, out_word);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_release_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_word !== 8'hC3) begin
      errors++; $display("[TB] FAIL stall_handover got v=%b w=%h want v=1 w=c3", out_valid, out_word);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    logic [7:0] w;
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF; words[3] = 8'h5A;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = words[k];
      for (int i = 7; i >= 0; i--) begin
        in_valid = 1'b1; in_bit = w[i];
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("[TB] FAIL stream_ready_w%0d_b%0d got %b want 1", k, i, in_ready);
        end
        tick();
        // A one-cycle gap with garbage on in_bit in the middle of word 2.
        if (k == 2 && i == 4) begin
          in_valid = 1'b0; in_bit = 1'b0;
          tick();
        end
      end
      checks++;
      if (out_valid !== 1'b1 || out_word !== w) begin
        errors++; $display("[TB] FAIL stream_word_%0d got v=%b w=%h want v=1 w=%h", k, out_valid, out_word, w);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stream_drain got v=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midword();
    out_ready = 1'b0;
    send_word(8'h77);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_word !== 8'h00) begin
      errors++; $display("[TB] FAIL midword_reset got v=%b w=%h want v=0 w=00", out_valid, out_word);
    end
    send_word(8'h12);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 8'h12) begin
      errors++; $display("[TB] FAIL midword_after got v=%b w=%h want v=1 w=12", out_valid, out_word);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  task automatic test_parity();
    logic pbit;
    out_ready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pbit = p[0];
      send_word(8'hA5);
      in_valid = 1'b1; in_bit = pbit;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_word !== 8'hA5 || out_parity_err !== pbit) begin
        errors++;
        $display("[TB] FAIL parity_%0d got v=%b w=%h e=%b want v=1 w=a5 e=%b", p, out_valid, out_word, out_parity_err, pbit);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_reset_midword();
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
